// File: rtl/radix_2_div_pkg.sv
// rtl/radix_2_div_pkg.sv - shared types and constants for the radix-2 sequential divider
package radix_2_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Width of an iteration counter that must hold the value dsize itself.
  function automatic int cnt_width(input int dsize);
    return $clog2(dsize + 1);
  endfunction

  // Quotient reported on divide-by-zero; sliced down to the dividend width.
  localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/radix_2_div_seq_if.sv
// rtl/radix_2_div_seq_if.sv - operand/result handshake bundle for the radix-2 divider
interface radix_2_div_seq_if #(
  parameter int DSIZE = 8,
  parameter int VSIZE = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] dividend;
  logic [VSIZE-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] quotient;
  logic [VSIZE-1:0] remainder;
  logic             div_zero;
  logic             ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero, ovf
  );
endinterface

// File: rtl/radix_2_div_step.sv
// rtl/radix_2_div_step.sv - one combinational restoring-division iteration
module radix_2_div_step #(
  parameter int VSIZE = 8
) (
  input  logic [VSIZE-1:0] rem_i,
  input  logic             bit_i,
  input  logic [VSIZE-1:0] div_i,
  output logic [VSIZE-1:0] rem_o,
  output logic             q_o
);

  // The shifted partial remainder needs VSIZE+1 bits; once the trial
  // subtract succeeds the difference is below the divisor, so its low
  // VSIZE bits are exact and the result always fits back into VSIZE bits.
  logic [VSIZE:0]   shifted;
  logic [VSIZE-1:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, div_i});
    diff    = shifted[VSIZE-1:0] - div_i;
    rem_o   = q_o ? diff : shifted[VSIZE-1:0];
  end

endmodule

// File: rtl/radix_2_div_seq.sv
// rtl/radix_2_div_seq.sv - iterative radix-2 restoring integer divider with valid/ready handshake
module radix_2_div_seq
  import radix_2_div_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int VSIZE  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clock,
  input  logic             rst,
  radix_2_div_seq_if.slave bus
);

  localparam int CW = cnt_width(DSIZE);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // quo_q starts as the dividend magnitude and is shifted out MSB first
  // while quotient bits shift in at the LSB, so one register serves both.
  logic [DSIZE-1:0] quo_q;
  logic [VSIZE-1:0] rem_q;
  logic [VSIZE-1:0] dvs_q;
  logic             q_neg_q, r_neg_q;
  logic             dz_q, ovf_q;

  logic             accept;
  logic             dvd_neg, dvs_neg, dvs_zero, is_ovf;
  logic [DSIZE-1:0] dvd_mag;
  logic [VSIZE-1:0] dvs_mag;
  logic [VSIZE-1:0] step_rem;
  logic             step_q;

  // Operand decode: signs, magnitudes and the special cases.
  always_comb begin
    accept   = bus.in_valid && (state_q == IDLE);
    dvd_neg  = SIGNED && bus.dividend[DSIZE-1];
    dvs_neg  = SIGNED && bus.divisor[VSIZE-1];
    dvd_mag  = dvd_neg ? -bus.dividend : bus.dividend;
    dvs_mag  = dvs_neg ? -bus.divisor : bus.divisor;
    dvs_zero = (bus.divisor == '0);
    is_ovf   = SIGNED && (bus.dividend == {1'b1, {(DSIZE-1){1'b0}}})
                      && (bus.divisor == '1);
  end

  radix_2_div_step #(.VSIZE(VSIZE)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[DSIZE-1]),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    case (state_q)
      IDLE: if (bus.in_valid) state_d = dvs_zero ? DONE : CALC;
      CALC: if (cnt_d == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, apply signs in FIX.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          cnt_q   <= CW'(DSIZE);
          dvs_q   <= dvs_mag;
          q_neg_q <= dvd_neg ^ dvs_neg;
          r_neg_q <= dvd_neg;
          dz_q    <= dvs_zero;
          ovf_q   <= is_ovf;
          if (dvs_zero) begin
            quo_q <= DIV_ZERO_QUOT[DSIZE-1:0];
            rem_q <= bus.dividend[VSIZE-1:0];
          end else begin
            quo_q <= dvd_mag;
            rem_q <= '0;
          end
        end
        CALC: begin
          quo_q <= {quo_q[DSIZE-2:0], step_q};
          rem_q <= step_rem;
          cnt_q <= cnt_d;
        end
        FIX: begin
          if (q_neg_q) quo_q <= -quo_q;
          if (r_neg_q) rem_q <= -rem_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_radix_2_div_seq.sv
// tb/tb_radix_2_div_seq.sv - directed and swept checks for radix_2_div_seq
module tb_radix_2_div_seq;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  // Per-instance stimulus and observation: 0=u8/8, 1=s8/8, 2=u16/8, 3=s16/8.
  logic        iv[4];
  logic        ordy[4];
  logic [15:0] dvd[4];
  logic [7:0]  dvs[4];
  logic        irdy[4];
  logic        ovld[4];
  logic [15:0] qo[4];
  logic [7:0]  ro[4];
  logic        dzo[4];
  logic        ovo[4];

  radix_2_div_seq_if #(.DSIZE(8),  .VSIZE(8)) if_u8 ();
  radix_2_div_seq_if #(.DSIZE(8),  .VSIZE(8)) if_s8 ();
  radix_2_div_seq_if #(.DSIZE(16), .VSIZE(8)) if_u16 ();
  radix_2_div_seq_if #(.DSIZE(16), .VSIZE(8)) if_s16 ();

  radix_2_div_seq #(.DSIZE(8),  .VSIZE(8), .SIGNED(1'b0)) u_u8  (.clock(clock), .rst(rst), .bus(if_u8));
  radix_2_div_seq #(.DSIZE(8),  .VSIZE(8), .SIGNED(1'b1)) u_s8  (.clock(clock), .rst(rst), .bus(if_s8));
  radix_2_div_seq #(.DSIZE(16), .VSIZE(8), .SIGNED(1'b0)) u_u16 (.clock(clock), .rst(rst), .bus(if_u16));
  radix_2_div_seq #(.DSIZE(16), .VSIZE(8), .SIGNED(1'b1)) u_s16 (.clock(clock), .rst(rst), .bus(if_s16));

  assign if_u8.in_valid  = iv[0];   assign if_u8.out_ready  = ordy[0];
  assign if_u8.dividend  = dvd[0][7:0]; assign if_u8.divisor = dvs[0];
  assign irdy[0] = if_u8.in_ready;  assign ovld[0] = if_u8.out_valid;
  assign qo[0] = {8'h00, if_u8.quotient}; assign ro[0] = if_u8.remainder;
  assign dzo[0] = if_u8.div_zero;   assign ovo[0] = if_u8.ovf;

  assign if_s8.in_valid  = iv[1];   assign if_s8.out_ready  = ordy[1];
  assign if_s8.dividend  = dvd[1][7:0]; assign if_s8.divisor = dvs[1];
  assign irdy[1] = if_s8.in_ready;  assign ovld[1] = if_s8.out_valid;
  assign qo[1] = {8'h00, if_s8.quotient}; assign ro[1] = if_s8.remainder;
  assign dzo[1] = if_s8.div_zero;   assign ovo[1] = if_s8.ovf;

  assign if_u16.in_valid = iv[2];   assign if_u16.out_ready = ordy[2];
  assign if_u16.dividend = dvd[2];  assign if_u16.divisor  = dvs[2];
  assign irdy[2] = if_u16.in_ready; assign ovld[2] = if_u16.out_valid;
  assign qo[2] = if_u16.quotient;   assign ro[2] = if_u16.remainder;
  assign dzo[2] = if_u16.div_zero;  assign ovo[2] = if_u16.ovf;

  assign if_s16.in_valid = iv[3];   assign if_s16.out_ready = ordy[3];
  assign if_s16.dividend = dvd[3];  assign if_s16.divisor  = dvs[3];
  assign irdy[3] = if_s16.in_ready; assign ovld[3] = if_s16.out_valid;
  assign qo[3] = if_s16.quotient;   assign ro[3] = if_s16.remainder;
  assign dzo[3] = if_s16.div_zero;  assign ovo[3] = if_s16.ovf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for out_valid, counting rising edges; lat already holds edges so far.
  task automatic wait_valid(input int sel, inout int lat);
    while (!ovld[sel] && lat < 200) begin
      @(posedge clock); lat++;
      @(negedge clock);
    end
    if (!ovld[sel]) check("timeout_out_valid", {63'd0, ovld[sel]}, 64'd1);
  endtask

  // Present one operation, measure edges until out_valid, then take the result.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [7:0] b,
                        output logic [15:0] q, output logic [7:0] r,
                        output logic dz, output logic ov, output int lat);
    @(negedge clock);
    dvd[sel] = a; dvs[sel] = b; iv[sel] = 1'b1;
    @(posedge clock); lat = 1;
    @(negedge clock); iv[sel] = 1'b0;
    wait_valid(sel, lat);
    q = qo[sel]; r = ro[sel]; dz = dzo[sel]; ov = ovo[sel];
    ordy[sel] = 1'b1;
    @(posedge clock);
    @(negedge clock); ordy[sel] = 1'b0;
  endtask

  // Reference for the 16/8 instances: {quotient, remainder, div_zero, ovf}.
  function automatic logic [25:0] ref_div(input bit sgn, input logic [15:0] a, input logic [7:0] b);
    longint sa, sb, lq, lr;
    logic [15:0] uq;
    logic [7:0]  ur;
    if (b == 8'h00) return {16'hFFFF, a[7:0], 1'b1, 1'b0};
    if (!sgn) begin
      uq = a / {8'h00, b};
      ur = 8'(a % {8'h00, b});
      return {uq, ur, 1'b0, 1'b0};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sa == -32768 && sb == -1) return {16'h8000, 8'h00, 1'b0, 1'b1};
    lq = sa / sb;
    lr = sa % sb;
    return {lq[15:0], lr[7:0], 1'b0, 1'b0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] q, a;
    logic [7:0]  r, b;
    logic        dz, ov, seen;
    int          lat, acc0, acc1, c;
    logic [25:0] expv;

    for (int i = 0; i < 4; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; dvd[i] = '0; dvs[i] = '0;
    end

    // Reset state, observed while reset is held.
    @(negedge clock); @(negedge clock);
    check("reset_u8", {irdy[0], ovld[0], qo[0][7:0], ro[0], dzo[0], ovo[0]}, {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    check("reset_s16", {irdy[3], ovld[3], qo[3], ro[3], dzo[3], ovo[3]}, {1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;

    // Unsigned 8/8 directed, including latency in edges from presentation.
    run_op(0, 16'd200, 8'd7, q, r, dz, ov, lat);
    check("u8_200_7", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'd28, 8'd4, 1'b0, 1'b0});
    run_op(0, 16'd77, 8'd0, q, r, dz, ov, lat);
    check("u8_77_0", {8'(lat), q[7:0], r, dz, ov}, {8'd1, 8'hFF, 8'd77, 1'b1, 1'b0});
    run_op(0, 16'd3, 8'd250, q, r, dz, ov, lat);
    check("u8_3_250", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'd0, 8'd3, 1'b0, 1'b0});
    run_op(0, 16'd255, 8'd1, q, r, dz, ov, lat);
    check("u8_255_1", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'd255, 8'd0, 1'b0, 1'b0});

    // Signed 8/8 directed.
    run_op(1, 16'h00F9, 8'h02, q, r, dz, ov, lat);
    check("s8_m7_2", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'hFD, 8'hFF, 1'b0, 1'b0});
    run_op(1, 16'h0007, 8'hFE, q, r, dz, ov, lat);
    check("s8_7_m2", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'hFD, 8'h01, 1'b0, 1'b0});
    run_op(1, 16'h0080, 8'hFF, q, r, dz, ov, lat);
    check("s8_m128_m1", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'h80, 8'h00, 1'b0, 1'b1});
    run_op(1, 16'h00F9, 8'hFE, q, r, dz, ov, lat);
    check("s8_m7_m2", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'h03, 8'hFF, 1'b0, 1'b0});
    run_op(1, 16'h00F0, 8'h00, q, r, dz, ov, lat);
    check("s8_m16_0", {8'(lat), q[7:0], r, dz, ov}, {8'd1, 8'hFF, 8'hF0, 1'b1, 1'b0});

    // Backpressure: result held, busy, and a stray in_valid is ignored.
    @(negedge clock);
    dvd[0] = 16'd100; dvs[0] = 8'd9; iv[0] = 1'b1;
    @(posedge clock); lat = 1;
    @(negedge clock); iv[0] = 1'b0;
    wait_valid(0, lat);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_%0d", i), {irdy[0], ovld[0], qo[0][7:0], ro[0], dzo[0], ovo[0]},
            {1'b0, 1'b1, 8'd11, 8'd1, 1'b0, 1'b0});
      if (i == 2) begin dvd[0] = 16'd5; dvs[0] = 8'd1; iv[0] = 1'b1; end
      if (i == 3) iv[0] = 1'b0;
      @(posedge clock); @(negedge clock);
    end
    ordy[0] = 1'b1;
    @(posedge clock); @(negedge clock); ordy[0] = 1'b0;
    check("bp_after_take", {irdy[0], ovld[0]}, {1'b1, 1'b0});
    run_op(0, 16'd5, 8'd1, q, r, dz, ov, lat);
    check("bp_next_op", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'd5, 8'd0, 1'b0, 1'b0});

    // Back-to-back throughput with in_valid and out_ready held high.
    @(negedge clock);
    dvd[0] = 16'd50; dvs[0] = 8'd5; iv[0] = 1'b1; ordy[0] = 1'b1;
    acc0 = -1; acc1 = -1;
    for (c = 0; c < 40 && acc1 < 0; c++) begin
      if (irdy[0]) begin
        if (acc0 < 0) acc0 = c; else acc1 = c;
      end
      @(posedge clock); @(negedge clock);
    end
    iv[0] = 1'b0;
    check("throughput", 64'(acc1 - acc0), 64'd11);
    for (c = 0; c < 40 && !irdy[0]; c++) begin @(posedge clock); @(negedge clock); end
    ordy[0] = 1'b0;
    check("throughput_drain", {irdy[0], ovld[0]}, {1'b1, 1'b0});

    // Asynchronous reset in the middle of CALC.
    @(negedge clock);
    dvd[0] = 16'd200; dvs[0] = 8'd7; iv[0] = 1'b1;
    @(posedge clock);
    @(negedge clock); iv[0] = 1'b0;
    repeat (3) @(posedge clock);
    #2 rst = 1'b1;
    #1 check("rst_mid_calc", {irdy[0], ovld[0], qo[0][7:0], ro[0], dzo[0], ovo[0]},
             {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    @(negedge clock); rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clock); @(negedge clock);
      seen = seen | ovld[0];
    end
    check("rst_no_result", {63'd0, seen}, 64'd0);
    run_op(0, 16'd255, 8'd16, q, r, dz, ov, lat);
    check("rst_next_op", {8'(lat), q[7:0], r, dz, ov}, {8'd10, 8'd15, 8'd15, 1'b0, 1'b0});

    // 16/8 sweeps in both modes against the reference.
    for (int sel = 2; sel < 4; sel++) begin
      for (int i = 0; i < 40; i++) begin
        a = 16'($urandom);
        b = 8'($urandom);
        if (i % 10 == 0) b = 8'h00;
        if (i % 10 == 1) begin
          a = 16'($urandom_range(0, 100));
          b = 8'($urandom_range(101, 127));
        end
        if (i == 2 && sel == 3) begin a = 16'h8000; b = 8'hFF; end
        expv = ref_div(sel == 3, a, b);
        run_op(sel, a, b, q, r, dz, ov, lat);
        check($sformatf("sweep%0d_%0d_%h_%h", sel, i, a, b), {8'(lat), q, r, dz, ov},
              {(b == 8'h00) ? 8'd1 : 8'd18, expv});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
